// File: rtl/router_pkg.sv
// Shared constants and header helpers for the 1x3 router datapath.
package router_pkg;

  localparam int unsigned ROUTER_DATA_W = 8;
  localparam int unsigned FIFO_DEPTH    = 16;
  localparam int unsigned FIFO_PTR_W    = 5;
  localparam int unsigned HDR_LEN_MSB   = 7;
  localparam int unsigned HDR_LEN_LSB   = 2;
  localparam int unsigned HDR_ADDR_MSB  = 1;
  localparam int unsigned HDR_ADDR_LSB  = 0;
  localparam int unsigned PKT_CNT_W     = 7;

  typedef logic [HDR_LEN_MSB-HDR_LEN_LSB:0] hdr_len_t;

  // Bytes still to come after a header: payload length plus the trailing parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_pkt_len(input hdr_len_t len);
    return PKT_CNT_W'(len) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Entry storage for router_fifo: one write port, one registered read port, no reset.
module router_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: tagged byte storage, full/empty flags and a
// packet-progress counter driven by header entries as they are read out.
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned DATA_W = ROUTER_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              empty,
  output logic              out_valid,
  output logic              pkt_busy,
  output logic [DATA_W-1:0] data_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 out_valid_q;
  logic                 cleared_q, cleared_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count;
  logic [DATA_W:0]      rd_entry;
  logic                 flush, do_wr, do_rd;

  assign flush = !resetn || soft_reset;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr = write_enb && !full && !flush;
  assign do_rd = read_enb && !empty && !flush;

  router_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_W + 1)
  ) u_mem (
    .clk    (clk),
    .wr_en  (do_wr),
    .wr_addr(wr_ptr_q[AW-1:0]),
    .wr_data({lfd_state, data_in}),
    .rd_en  (do_rd),
    .rd_addr(rd_ptr_q[AW-1:0]),
    .rd_data(rd_entry)
  );

  // The entry read on the last edge only appears at the memory output afterwards, so its effect
  // on the count is applied here and folded into pkt_count_q on the following edge.
  always_comb begin
    pkt_count = pkt_count_q;
    if (out_valid_q) begin
      if (rd_entry[DATA_W]) begin
        pkt_count = hdr_pkt_len(rd_entry[HDR_LEN_MSB:HDR_LEN_LSB]);
      end else if (pkt_count_q != '0) begin
        pkt_count = pkt_count_q - PKT_CNT_W'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cleared_d = cleared_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      cleared_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      cleared_q   <= 1'b1;
      pkt_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= do_rd;
      cleared_q   <= cleared_d;
      pkt_count_q <= pkt_count;
    end
  end

  assign out_valid = out_valid_q;
  assign pkt_busy  = (pkt_count != '0);
  // Read data register is reset-free, so mask it until the first read after a flush.
  assign data_out  = cleared_q ? '0 : rd_entry[DATA_W-1:0];

endmodule
